// File: rtl/data_mem_unit.sv
// data_mem_unit: data memory stage for the CPU datapath.
// This stage handles byte, halfword and word loads and stores. Loads are sign- or
// zero-extended. Access latency is set by a wait-state counter.
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-high reset
//   mem_read_i     load request
//   mem_write_i    store request (wins over a load when both are asserted)
//   funct3_i       access type (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   addr_i         little-endian byte address
//   write_data_i   store data (low byte/half/word used)
//   mem_data_o     extended load result, held until the next successful load
//   busy_o         request in flight; new requests ignored
//   done_o         one-cycle completion pulse
//   misaligned_o   alignment/encoding error, valid only while done_o is high
module data_mem_unit #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] mem_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        misaligned_o
);
    localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  CntInit = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        mis_q, mis_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    // With zero wait states the access commits on the accept edge itself, so the
    // access fields come straight from the inputs while idle.
    logic            acc_write;
    logic [2:0]      acc_f3;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [IdxW-1:0] idx;
    logic [31:0]     rd_word;
    logic [31:0]     byte_sh;
    logic [31:0]     half_sh;
    logic [31:0]     load_val;
    logic            acc_ok;
    logic [3:0]      be;
    logic [31:0]     st_data;
    logic [31:0]     merged;
    logic            commit;

    always_comb begin
        if (state_q == StIdle) begin
            acc_write = mem_write_i;
            acc_f3    = funct3_i;
            acc_addr  = addr_i;
            acc_wdata = write_data_i;
        end else begin
            acc_write = write_q;
            acc_f3    = funct3_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign idx     = acc_addr[IdxW+1:2];
    assign rd_word = mem_q[idx];
    assign byte_sh = rd_word >> {acc_addr[1:0], 3'b000};
    assign half_sh = rd_word >> {acc_addr[1], 4'b0000};

    always_comb begin
        acc_ok   = 1'b0;
        load_val = rd_word;
        be       = 4'b0000;
        st_data  = acc_wdata;
        case (acc_f3)
            3'b000: begin
                acc_ok   = 1'b1;
                load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
                be       = 4'b0001 << acc_addr[1:0];
                st_data  = {4{acc_wdata[7:0]}};
            end
            3'b001: begin
                acc_ok   = ~acc_addr[0];
                load_val = {{16{half_sh[15]}}, half_sh[15:0]};
                be       = acc_addr[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{acc_wdata[15:0]}};
            end
            3'b010: begin
                acc_ok   = (acc_addr[1:0] == 2'b00);
                load_val = rd_word;
                be       = 4'b1111;
            end
            3'b100: begin
                acc_ok   = ~acc_write;
                load_val = {24'd0, byte_sh[7:0]};
            end
            3'b101: begin
                acc_ok   = ~acc_write & ~acc_addr[0];
                load_val = {16'd0, half_sh[15:0]};
            end
            default: acc_ok = 1'b0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? st_data[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (mem_read_i || mem_write_i) begin
                    write_d  = mem_write_i;
                    funct3_d = funct3_i;
                    addr_d   = addr_i;
                    wdata_d  = write_data_i;
                    cnt_d    = CntInit;
                    state_d  = (WAIT_STATES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign commit = (state_d == StResp) && (state_q != StResp);

    always_comb begin
        mem_data_d = mem_data_q;
        mis_d      = mis_q;
        if (commit) begin
            mis_d = ~acc_ok;
            if (acc_ok && !acc_write) begin
                mem_data_d = load_val;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            write_q    <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            mem_data_q <= 32'd0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_data_q <= mem_data_d;
            mis_q      <= mis_d;
        end
    end

    // Storage has no reset; a store pending when reset hits must be dropped.
    always_ff @(posedge clk_i) begin
        if (commit && acc_write && acc_ok && !rst_i) begin
            mem_q[idx] <= merged;
        end
    end

    assign mem_data_o   = mem_data_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StResp);
    assign misaligned_o = done_o & mis_q;
endmodule
